// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI slave responder backed by a word-addressed memory array
//
// Purpose: terminates one crossbar slave port with NUM_WORDS x 32-bit memory.
// Requests get a combinational grant. Every transaction, read or write, is
// answered in grant order exactly LATENCY cycles after its grant. No more than
// MAX_OUTSTANDING transactions are in flight at any time.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_i          synchronous, active-high reset
//   slave_req_i    OBI request  {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   slave_resp_o   OBI response {gnt, rvalid, rdata[31:0]}
//   outstanding_o  current count of granted-but-unanswered transactions
//
// Optional feature: define OBI_MEM_RESP_STALL_EN to add a pseudo-random
// grant stall. A 16-bit LFSR blocks the grant in about one cycle in four.

package obi_mem_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder #(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter type         obi_req_t       = obi_mem_pkg::obi_req_t,
  parameter type         obi_resp_t      = obi_mem_pkg::obi_resp_t,
  localparam int unsigned AW             = $clog2(NUM_WORDS),
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  obi_req_t      slave_req_i,
  output obi_resp_t     slave_resp_o,
  output logic [CW-1:0] outstanding_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("obi_mem_responder: LATENCY must be within 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_max_out
    $error("obi_mem_responder: MAX_OUTSTANDING must be within 1..LATENCY+1");
  end
  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_num_words
    $error("obi_mem_responder: NUM_WORDS must be a power of two, at least 2");
  end

  logic [31:0]               r_mem [NUM_WORDS];
  logic [LATENCY-1:0]        r_valid;
  logic [LATENCY-1:0][31:0]  r_data;
  logic [CW-1:0]             r_cnt;

  logic [AW-1:0] w_idx;
  logic          w_stall;
  logic          w_retire;
  logic          w_gnt;
  logic          w_unused_addr;

  // Only the word index selects storage. The byte offset and the upper bits
  // are dropped, so addresses alias modulo the array size.
  assign w_idx         = slave_req_i.addr[AW+1:2];
  assign w_unused_addr = ^{slave_req_i.addr[31:AW+2], slave_req_i.addr[1:0]};

`ifdef OBI_MEM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci LFSR with taps 16,14,13,11. It keeps running while requests
  // are idle, so the stall pattern does not depend on the traffic.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // The response in the last stage retires this cycle. It is gated by reset
  // so that in-flight responses disappear as soon as reset is seen.
  assign w_retire = r_valid[LATENCY-1] & ~rst_i;

  // A retirement frees a slot in the same cycle. This lets a full pipe accept
  // a new request while it hands one back.
  assign w_gnt = slave_req_i.req & ~rst_i & ~w_stall &
                 ((r_cnt < MAX_CNT) | w_retire);

  // Byte-lane writes at the granting edge. The array is never reset.
  always_ff @(posedge clk_i) begin
    if (w_gnt && slave_req_i.we) begin
      for (int k = 0; k < 4; k++) begin
        if (slave_req_i.be[k]) begin
          r_mem[w_idx][8*k +: 8] <= slave_req_i.wdata[8*k +: 8];
        end
      end
    end
  end

  // Response pipeline. Read data is captured at the grant edge, so later
  // writes to the same word cannot change a read that is already in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid[0] <= w_gnt;
      r_data[0]  <= (w_gnt && !slave_req_i.we) ? r_mem[w_idx] : 32'h0;
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  // In-flight counter. A grant and a retirement in the same cycle cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_gnt && !w_retire) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_gnt && w_retire) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    slave_resp_o        = '0;
    slave_resp_o.gnt    = w_gnt;
    slave_resp_o.rvalid = w_retire;
    slave_resp_o.rdata  = w_retire ? r_data[LATENCY-1] : 32'h0;
  end

  assign outstanding_o = rst_i ? '0 : r_cnt;

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - randomized and directed bench for obi_mem_responder
module tb_obi_mem_responder;

  localparam int NW   = 16;
  localparam int LAT  = 3;
  localparam int MAXO = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  obi_mem_pkg::obi_req_t  req_s;
  obi_mem_pkg::obi_resp_t resp_s;
  logic [1:0]             outstanding;

  obi_mem_responder #(
    .NUM_WORDS       (NW),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slave_req_i   (req_s),
    .slave_resp_o  (resp_s),
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Reference model: a memory image plus a queue of time-stamped pending responses.
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic [31:0] m_mem [NW];
  exp_t        eq [$];
  logic [31:0] got_q [$];
  int          cyc = 0;
  int          stall_seen = 0;
  logic        e_gnt, e_rv, allowed, grant_now;
  logic [31:0] e_rd;
  int          e_out;
  int          midx;

  // Per-cycle compare, done at the falling edge while inputs are stable. The
  // model then advances to the state that follows the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      e_gnt = 1'b0; e_rv = 1'b0; e_rd = 32'h0; e_out = 0; allowed = 1'b0;
    end else begin
      e_rv    = (eq.size() > 0) && (eq[0].due == cyc);
      e_rd    = e_rv ? eq[0].data : 32'h0;
      e_out   = eq.size();
      allowed = req_s.req && ((eq.size() < MAXO) || e_rv);
      e_gnt   = allowed;
    end
`ifdef OBI_MEM_RESP_STALL_EN
    if (rst) begin
      chk("gnt", {31'h0, resp_s.gnt}, {31'h0, e_gnt});
    end else begin
      chk("gnt_legal", {31'h0, resp_s.gnt && !allowed}, 32'h0);
      if (allowed && !resp_s.gnt) stall_seen++;
    end
    grant_now = resp_s.gnt && allowed;
`else
    chk("gnt", {31'h0, resp_s.gnt}, {31'h0, e_gnt});
    grant_now = e_gnt;
`endif
    chk("rvalid", {31'h0, resp_s.rvalid}, {31'h0, e_rv});
    chk("rdata", resp_s.rdata, e_rd);
    chk("outstanding", {30'h0, outstanding}, e_out);
    if (resp_s.rvalid) got_q.push_back(resp_s.rdata);

    if (rst) begin
      eq.delete();
    end else begin
      if (e_rv) void'(eq.pop_front());
      if (grant_now) begin
        midx = int'(req_s.addr[5:2]);
        eq.push_back('{due: cyc + LAT, data: req_s.we ? 32'h0 : m_mem[midx]});
        if (req_s.we) begin
          for (int k = 0; k < 4; k++) begin
            if (req_s.be[k]) m_mem[midx][8*k +: 8] = req_s.wdata[8*k +: 8];
          end
        end
      end
    end
    cyc++;
  end

  task automatic idle(input int n);
    req_s.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until the grant arrives, as a master must.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    logic g;
    int   n;
    req_s.req   = 1'b1;
    req_s.we    = we;
    req_s.addr  = addr;
    req_s.wdata = wdata;
    req_s.be    = be;
    n = 0;
    g = 1'b0;
    while (!g && n < 200) begin
      @(negedge clk);
      g = resp_s.gnt;
      @(posedge clk);
      #1;
      n++;
    end
    if (!g) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout actual=0 required=1");
    end
    req_s.req = 1'b0;
  endtask

  logic [31:0] cap_gnt [5];
  logic [31:0] cap_out [5];
  logic [31:0] cap_rv  [5];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    req_s = '0;
    repeat (3) @(posedge clk);
    #1;
    // Even a live request gets nothing while reset is held.
    req_s.req = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {31'h0, resp_s.gnt}, 32'h0);
    chk("rst_rvalid", {31'h0, resp_s.rvalid}, 32'h0);
    chk("rst_outstanding", {30'h0, outstanding}, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_s.req = 1'b0;

    for (int i = 0; i < NW; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF);
    idle(8);

    got_q.delete();
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'h0);
    idle(8);
    chk("basic_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("basic_wr_rdata", got_q[0], 32'h0);
      chk("basic_rd_rdata", got_q[1], 32'hDEADBEEF);
    end

    got_q.delete();
    do_req(1'b1, 32'h0, 32'h11223344, 4'hF);
    do_req(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101);
    do_req(1'b0, 32'h0, 32'h0, 4'h0);
    idle(8);
    chk("be_count", got_q.size(), 3);
    if (got_q.size() == 3) chk("be_rdata", got_q[2], 32'h11BB33DD);

    got_q.delete();
    do_req(1'b1, 32'h40, 32'h5A5A5A5A, 4'hF);
    do_req(1'b0, 32'h00, 32'h0, 4'h0);
    do_req(1'b0, 32'hFFFFFF03, 32'h0, 4'h0);
    idle(8);
    chk("wrap_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("wrap_rdata0", got_q[1], 32'h5A5A5A5A);
      chk("wrap_rdata1", got_q[2], 32'h5A5A5A5A);
    end

`ifndef OBI_MEM_RESP_STALL_EN
    // Back-to-back reads with the request held against a cap of two.
    req_s.req = 1'b1; req_s.we = 1'b0; req_s.addr = 32'h8; req_s.be = 4'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cap_gnt[c] = {31'h0, resp_s.gnt};
      cap_out[c] = {30'h0, outstanding};
      cap_rv[c]  = {31'h0, resp_s.rvalid};
      @(posedge clk);
      #1;
    end
    idle(8);
    chk("cap_gnt0", cap_gnt[0], 1); chk("cap_gnt1", cap_gnt[1], 1);
    chk("cap_gnt2", cap_gnt[2], 0); chk("cap_gnt3", cap_gnt[3], 1);
    chk("cap_out0", cap_out[0], 0); chk("cap_out1", cap_out[1], 1);
    chk("cap_out2", cap_out[2], 2); chk("cap_out3", cap_out[3], 2);
    chk("cap_out4", cap_out[4], 2);
    chk("cap_rv2", cap_rv[2], 0);   chk("cap_rv3", cap_rv[3], 1);

    // Two reads in flight, then reset before either can answer.
    got_q.delete();
    req_s.req = 1'b1; req_s.we = 1'b0; req_s.addr = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", {31'h0, resp_s.gnt}, 32'h0);
    chk("midrst_rvalid", {31'h0, resp_s.rvalid}, 32'h0);
    chk("midrst_outstanding", {30'h0, outstanding}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    chk("midrst_no_resp", got_q.size(), 0);
`endif

    got_q.delete();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
      do_req(1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    idle(12);
    chk("rand_resp_count", got_q.size(), 1000);
`ifdef OBI_MEM_RESP_STALL_EN
    chk("stall_seen", {31'h0, stall_seen > 0}, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
